// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit for the execute stage.
// Multiply: iterative shift-add on operand magnitudes, sign applied at the end.
// Divide: non-restoring shift-subtract on magnitudes, sign applied at the end.
// Each operation takes WIDTH+1 edges from the start edge to the result edge.
module multdiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      counter;
  // hi: multiply upper accumulator / divide partial remainder (signed, WIDTH+1)
  // lo: multiplier shifting out / quotient shifting in
  logic [WIDTH:0]     hi;
  logic [WIDTH-1:0]   lo;
  // opnd: multiplicand magnitude / divisor magnitude
  logic [WIDTH-1:0]   opnd;
  logic               op_mult;
  logic               neg_result;
  logic               div_zero;
  logic               div_ovf;

  logic               start;
  logic               last_iter;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_new;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic               mult_exc;
  logic [WIDTH-1:0]   quo_s;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (counter == CW'(WIDTH-1));

  // Operand magnitudes and per-iteration arithmetic
  always_comb begin
    a_mag     = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
    b_mag     = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;
    mult_sum  = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
    div_new   = hi[WIDTH] ? (div_shift + {1'b0, opnd})
                          : (div_shift - {1'b0, opnd});
    prod      = {hi[WIDTH-1:0], lo};
    prod_s    = neg_result ? ('0 - prod) : prod;
    mult_exc  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    quo_s     = neg_result ? ('0 - lo) : lo;
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: a start from any state begins a new op, MULT taking priority
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ctrl_MULT ? MULT : DIV;
    end else begin
      unique case (state)
        MULT, DIV: if (last_iter) state_next = DONE;
        DONE:      state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Iteration counter: cleared on start, saturates at the final iteration
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= '0;
    end else if (start) begin
      counter <= '0;
    end else if ((state == MULT || state == DIV) && !last_iter) begin
      counter <= counter + 1'b1;
    end
  end

  // Datapath: operand latch, iteration, and result registration in DONE.
  // A start coinciding with DONE still publishes the finished result while
  // loading the new operands on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi             <= '0;
      lo             <= '0;
      opnd           <= '0;
      op_mult        <= 1'b0;
      neg_result     <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == DONE) begin
        data_resultRDY <= 1'b1;
        if (op_mult) begin
          data_result    <= prod_s[WIDTH-1:0];
          data_exception <= mult_exc;
        end else if (div_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= quo_s;
          data_exception <= div_ovf;
        end
      end

      if (start) begin
        hi         <= '0;
        lo         <= ctrl_MULT ? b_mag : a_mag;
        opnd       <= ctrl_MULT ? a_mag : b_mag;
        op_mult    <= ctrl_MULT;
        neg_result <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero   <= !ctrl_MULT && (data_operandB == '0);
        div_ovf    <= !ctrl_MULT && (data_operandA == MIN_NEG) && (data_operandB == '1);
      end else begin
        unique case (state)
          MULT: begin
            hi <= {1'b0, mult_sum[WIDTH:1]};
            lo <= {mult_sum[0], lo[WIDTH-1:1]};
          end
          DIV: begin
            hi <= div_new;
            lo <= {lo[WIDTH-2:0], ~div_new[WIDTH]};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Testbench for multdiv_unit: table-driven vectors through a scoreboard queue,
// plus hand-written restart, async-abort and simultaneous-start sequences.
module tb_multdiv_unit;

  localparam int unsigned WIDTH = 32;
  localparam int LATENCY = 33;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  multdiv_unit #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic             m;
    logic             d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             exc;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             exc;
  } exp_t;

  vec_t vecs[14];
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drive a start pulse at the negedge; returns #1 after the start edge E0
  // with the operand inputs scrambled to show they are don't-care.
  task automatic start_op(input logic m, input logic d,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait (bounded) for RDY, check latency and scoreboard, then the E34 drop.
  task automatic wait_and_check(input string tag);
    int   cycles;
    exp_t e;
    logic [WIDTH-1:0] held;
    cycles = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cycles = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(cycles), 64'(LATENCY));
    if (cycles != 0) begin
      if (sbq.size() == 0) begin
        check({tag, "_sb_nonempty"}, 64'(0), 64'(1));
      end else begin
        e = sbq.pop_front();
        check({tag, "_result"}, 64'(data_result), 64'(e.res));
        check({tag, "_exc"}, 64'(data_exception), 64'(e.exc));
      end
    end
    held = data_result;
    @(posedge clock);
    #1;
    check({tag, "_rdy_low_e34"}, 64'(data_resultRDY), 64'(0));
    check({tag, "_hold"}, 64'(data_result), 64'(held));
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] res, input logic exc);
    exp_t e;
    e.res = res;
    e.exc = exc;
    sbq.push_back(e);
  endtask

  initial begin
    int rdy_cnt;

    vecs[0]  = '{1'b1, 1'b0, 32'd3,        32'hFFFFFFFC, 32'hFFFFFFF4, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'd3,        32'd7,        32'd0,        1'b0};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        1'b0};

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", 64'(data_result), 64'(0));
    check("reset_exc", 64'(data_exception), 64'(0));
    check("reset_rdy", 64'(data_resultRDY), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      push_exp(vecs[i].res, vecs[i].exc);
      start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
      wait_and_check($sformatf("vec%0d", i));
    end

    // Restart: MULT 6*7 discarded by a DIV 100/7 started ten edges later
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (9) @(posedge clock);
    push_exp(32'd14, 1'b0);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_and_check("restart");
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    check("restart_no_extra_rdy", 64'(rdy_cnt), 64'(0));

    // Asynchronous reset in the middle of a MULT
    start_op(1'b1, 1'b0, 32'd1234, 32'd5678);
    repeat (19) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("abort_result", 64'(data_result), 64'(0));
    check("abort_exc", 64'(data_exception), 64'(0));
    check("abort_rdy", 64'(data_resultRDY), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) rdy_cnt++;
    end
    check("abort_no_rdy", 64'(rdy_cnt), 64'(0));

    // Simultaneous MULT and DIV: MULT wins
    push_exp(32'd18, 1'b0);
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    wait_and_check("both");

    check("sb_drained", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
